// File: rtl/cl_frame_buf_mc_if.sv
// Cache-line stream bundle: frame sink in, frame source out.
// slave = buffer side, master = producer/consumer side.
interface cl_frame_buf_mc_if #(
  parameter int CL    = 512,
  parameter int LEN_W = 11
);
  logic             sink_valid;
  logic [CL-1:0]    sink_data;
  logic             sink_ready;
  logic             src_rdy;
  logic             src_rdreq;
  logic [CL-1:0]    src_data;
  logic             src_sop;
  logic             src_eop;
  logic [LEN_W-1:0] sb_len;

  modport master (
    output sink_valid, sink_data, src_rdreq,
    input  sink_ready, src_rdy, src_data,
    input  src_sop, src_eop, sb_len
  );

  modport slave (
    input  sink_valid, sink_data, src_rdreq,
    output sink_ready, src_rdy, src_data,
    output src_sop, src_eop, sb_len
  );
endinterface

// File: rtl/cl_frame_buf_mc.sv
// Frame-aware CL buffer: parses headers, stores whole frames,
// exposes only committed frames with self-tracked sop/eop.
module cl_frame_buf_mc #(
  parameter int CL        = 512,
  parameter int CL_HEAD   = 16,
  parameter int LEN_W     = 11,
  parameter int DEPTH     = 1024,
  parameter int FRM_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cl_frame_buf_mc_if.slave           bus,
  output logic [$clog2(FRM_DEPTH):0] frm_cnt,
  output logic                       err_hdr,
  output logic [15:0]                drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FRM_DEPTH);
  localparam int CW = FW + 1;

  localparam logic [AW:0]      P_ONE = (AW+1)'(1);
  localparam logic [FW-1:0]    F_ONE = FW'(1);
  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    W_HEAD,
    W_BODY,
    W_DROP
  } wst_t;

  wst_t st, st_nxt;

  logic [CL-1:0]    mem  [DEPTH];
  logic [LEN_W-1:0] lmem [FRM_DEPTH];

  logic [AW:0]      wptr, rptr;
  logic [FW-1:0]    lwp, lrp;
  logic [LEN_W-1:0] wrem, wlen, rrem;
  logic [LEN_W-1:0] len, hd_len, cur_rem, clen;
  logic [CL-1:0]    hold;
  logic             rd_mid, rdy_en, full;
  logic             xfer, hdr_bad;
  logic             wr_en, commit, reject;
  logic             pop, eop;

  assign len     = bus.sink_data[CL-CL_HEAD +: LEN_W];
  assign hdr_bad = (len == '0) || (32'(len) > DEPTH);
  assign xfer    = bus.sink_valid && bus.sink_ready;
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

  // rdy_en keeps the sink closed until the first edge after reset
  always_comb begin
    bus.sink_ready = 1'b0;
    if (rdy_en) begin
      unique case (st)
        W_DROP:  bus.sink_ready = 1'b1;
        W_BODY:  bus.sink_ready = !full;
        default: bus.sink_ready = !full &&
                   (frm_cnt < CW'(FRM_DEPTH));
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= W_HEAD;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (xfer) begin
      unique case (st)
        W_HEAD: begin
          unique case (1'b1)
            hdr_bad:      st_nxt = (len > L_ONE) ? W_DROP : W_HEAD;
            len == L_ONE: st_nxt = W_HEAD;
            default:      st_nxt = W_BODY;
          endcase
        end
        W_BODY:  if (wrem == L_ONE) st_nxt = W_HEAD;
        W_DROP:  if (wrem == L_ONE) st_nxt = W_HEAD;
        default: st_nxt = W_HEAD;
      endcase
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    commit = 1'b0;
    reject = 1'b0;
    if (xfer) begin
      unique case (st)
        W_HEAD: begin
          reject = hdr_bad;
          wr_en  = !hdr_bad;
          commit = !hdr_bad && (len == L_ONE);
        end
        W_BODY: begin
          wr_en  = 1'b1;
          commit = (wrem == L_ONE);
        end
        default: ;
      endcase
    end
  end

  assign clen = (st == W_HEAD) ? len : wlen;

  // Read side: rrem is live only once the head frame is in flight
  assign hd_len  = lmem[lrp];
  assign cur_rem = rd_mid ? rrem : hd_len;
  assign eop     = bus.src_rdy && (cur_rem == L_ONE);
  assign pop     = bus.src_rdy && bus.src_rdreq;

  assign bus.src_rdy  = (frm_cnt != '0);
  assign bus.src_sop  = bus.src_rdy && !rd_mid;
  assign bus.src_eop  = eop;
  assign bus.sb_len   = bus.src_rdy ? hd_len : '0;
  assign bus.src_data = bus.src_rdy ? mem[rptr[AW-1:0]] : hold;

  always_ff @(posedge clk) begin
    if (wr_en)  mem[wptr[AW-1:0]] <= bus.sink_data;
    if (commit) lmem[lwp]         <= clen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      lwp      <= '0;
      lrp      <= '0;
      wrem     <= '0;
      wlen     <= '0;
      rrem     <= '0;
      rd_mid   <= 1'b0;
      rdy_en   <= 1'b0;
      hold     <= '0;
      frm_cnt  <= '0;
      err_hdr  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rdy_en  <= 1'b1;
      err_hdr <= reject;
      if (reject && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      if (xfer) begin
        if (st == W_HEAD) begin
          wrem <= len - L_ONE;
          wlen <= len;
        end else begin
          wrem <= wrem - L_ONE;
        end
      end
      if (wr_en)  wptr <= wptr + P_ONE;
      if (commit) lwp  <= lwp + F_ONE;
      if (bus.src_rdy) hold <= mem[rptr[AW-1:0]];
      if (pop) begin
        rptr   <= rptr + P_ONE;
        rd_mid <= !eop;
        rrem   <= cur_rem - L_ONE;
        if (eop) lrp <= lrp + F_ONE;
      end
      frm_cnt <= frm_cnt + CW'(commit) - CW'(pop && eop);
    end
  end
endmodule

// File: tb/tb_cl_frame_buf_mc.sv
// Randomized bench for cl_frame_buf_mc against a
// frame-level queue model.
module tb_cl_frame_buf_mc;
  localparam int CL        = 512;
  localparam int CL_HEAD   = 16;
  localparam int LEN_W     = 11;
  localparam int DEPTH     = 1024;
  localparam int FRM_DEPTH = 16;
  localparam int CW        = $clog2(FRM_DEPTH) + 1;

  typedef struct {
    logic [CL-1:0] d;
    bit            sop;
    bit            eop;
    int            len;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CW-1:0] frm_cnt;
  logic          err_hdr;
  logic [15:0]   drop_cnt;

  cl_frame_buf_mc_if #(.CL(CL), .LEN_W(LEN_W)) bus ();

  cl_frame_buf_mc #(
    .CL(CL), .CL_HEAD(CL_HEAD), .LEN_W(LEN_W),
    .DEPTH(DEPTH), .FRM_DEPTH(FRM_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .frm_cnt(frm_cnt),
    .err_hdr(err_hdr),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  ent_t          exp_q[$];
  logic [CL-1:0] part[$];
  int            need, flen, m_frm, m_drops, n_out;
  bit            dropping, err_pend;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag,
                       input logic [CL-1:0] got,
                       input logic [CL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CL-1:0] mk(input int l);
    logic [CL-1:0] d;
    for (int i = 0; i < CL/32; i++) d[i*32 +: 32] = $urandom;
    d[CL-1 -: CL_HEAD] = CL_HEAD'(l);
    return d;
  endfunction

  task automatic model_write(input logic [CL-1:0] d);
    ent_t e;
    int   l;
    l = int'(d[CL-CL_HEAD +: LEN_W]);
    if (need == 0) begin
      dropping = 0;
      if (l == 0 || l > DEPTH) begin
        if (m_drops < 65535) m_drops++;
        err_pend = 1;
        if (l > 1) begin
          need = l - 1;
          dropping = 1;
        end
      end else begin
        part.delete();
        part.push_back(d);
        flen = l;
        need = l - 1;
      end
    end else begin
      need--;
      if (!dropping) part.push_back(d);
    end
    if (need == 0 && !dropping && part.size() != 0) begin
      foreach (part[i]) begin
        e.d   = part[i];
        e.sop = (i == 0);
        e.eop = (i == flen - 1);
        e.len = flen;
        exp_q.push_back(e);
      end
      m_frm++;
      part.delete();
    end
  endtask

  task automatic step(input bit v, input logic [CL-1:0] d,
                      input bit rq, output bit acc);
    ent_t e;
    bit   rdy_exp, pop;
    int   stored;
    bus.sink_valid = v;
    bus.sink_data  = d;
    bus.src_rdreq  = rq;
    @(negedge clk);
    stored = exp_q.size() + part.size();
    if (need > 0 && dropping) rdy_exp = 1;
    else rdy_exp = (stored < DEPTH) &&
                   (need > 0 || m_frm < FRM_DEPTH);
    check("sink_ready", bus.sink_ready, rdy_exp);
    check("frm_cnt", frm_cnt, m_frm);
    check("src_rdy", bus.src_rdy, m_frm != 0);
    check("err_hdr", err_hdr, err_pend);
    check("drop_cnt", drop_cnt, m_drops);
    if (m_frm != 0 && exp_q.size() != 0) begin
      e = exp_q[0];
      check("src_data", bus.src_data, e.d);
      check("src_sop", bus.src_sop, e.sop);
      check("src_eop", bus.src_eop, e.eop);
      check("sb_len", bus.sb_len, e.len);
    end else begin
      check("idle_sop", bus.src_sop, 0);
      check("idle_eop", bus.src_eop, 0);
    end
    acc = v && bus.sink_ready;
    pop = rq && bus.src_rdy;
    err_pend = 0;
    if (pop && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_out++;
      if (e.eop) m_frm--;
    end
    if (acc) model_write(d);
    @(posedge clk);
    #1;
  endtask

  task automatic send_cl(input logic [CL-1:0] d,
                         input int vp, input int rp);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 4000) begin
      step($urandom_range(99) < vp, d,
           $urandom_range(99) < rp, acc);
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input int l, input int n,
                            input int vp, input int rp);
    send_cl(mk(l), vp, rp);
    for (int i = 1; i < n; i++) send_cl(mk(0), vp, rp);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      step(0, '0, 1, acc);
      n++;
    end
    step(0, '0, 0, acc);
    check("drained", frm_cnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.sink_valid = 0;
    bus.sink_data  = '0;
    bus.src_rdreq  = 0;
    #1;
    check("rst_sink_ready", bus.sink_ready, 0);
    check("rst_src_rdy", bus.src_rdy, 0);
    check("rst_sop", bus.src_sop, 0);
    check("rst_eop", bus.src_eop, 0);
    check("rst_sb_len", bus.sb_len, 0);
    check("rst_frm_cnt", frm_cnt, 0);
    check("rst_err_hdr", err_hdr, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_src_data", bus.src_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    exp_q.delete();
    part.delete();
    need = 0;
    dropping = 0;
    m_frm = 0;
    m_drops = 0;
    err_pend = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            acc;
    int            base, l;
    logic [CL-1:0] d17;
    n_out = 0;
    #2;
    do_reset();

    // back-to-back frames 3,1,4 with reads held high
    base = n_out;
    send_frame(3, 3, 100, 100);
    send_frame(1, 1, 100, 100);
    send_frame(4, 4, 100, 100);
    drain();
    check("seq_out_cnt", n_out - base, 8);

    // src_rdy only after the last CL of a len=5 frame
    send_frame(5, 5, 100, 0);
    step(0, '0, 0, acc);
    check("len5_frm_cnt", frm_cnt, 1);
    drain();

    // illegal and oversized headers dropped
    base = n_out;
    send_frame(0, 1, 100, 0);
    send_frame(2000, 2000, 100, 0);
    send_frame(2, 2, 100, 0);
    drain();
    check("drop_total", drop_cnt, 2);
    check("drop_out_cnt", n_out - base, 2);

    // frame-queue full blocks the 17th header
    for (int i = 0; i < 16; i++) send_frame(1, 1, 100, 0);
    d17 = mk(1);
    step(1, d17, 0, acc);
    check("frm_full_blk", acc, 0);
    step(1, d17, 1, acc);
    check("frm_full_blk2", acc, 0);
    send_cl(d17, 100, 0);
    drain();

    // long frames across pointer wrap with concurrent reads
    base = n_out;
    for (int i = 0; i < 6; i++) send_frame(512, 512, 85, 60);
    drain();
    check("wrap_out_cnt", n_out - base, 6 * 512);

    // mixed random frames with occasional bad headers
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9) == 0) begin
        l = ($urandom_range(1) == 0) ? 0 :
            DEPTH + 1 + int'($urandom_range(40));
        send_frame(l, (l == 0) ? 1 : l, 70, 50);
      end else begin
        l = 1 + int'($urandom_range(39));
        send_frame(l, l, 70, 50);
      end
    end
    drain();

    // reset mid-body with two committed frames
    send_frame(2, 2, 100, 0);
    send_frame(2, 2, 100, 0);
    send_cl(mk(6), 100, 0);
    send_cl(mk(0), 100, 0);
    send_cl(mk(0), 100, 0);
    do_reset();
    base = n_out;
    send_frame(3, 3, 100, 100);
    drain();
    check("post_rst_out", n_out - base, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
